// File: rtl/move_input_ctrl.sv
// Turns four raw push-buttons into one debounced move request per press.
// Buttons are synchronized, debounced, priority-resolved (L>R>U>D) and held off until all are released.
module move_input_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_L,
   input  logic        btn_R,
   input  logic        btn_U,
   input  logic        btn_D,
   output logic        move_valid,
   output logic [1:0]  move_dir,
   input  logic        move_ready,
   output logic [15:0] move_count,
   output logic [3:0]  btn_db
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {StIdle, StReq, StWaitRel} state_e;

   logic [3:0]       raw;
   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       db;
   logic [CNT_W-1:0] cnt [4];
   logic [1:0]       prio_dir;
   state_e           state;

   assign raw    = {btn_L, btn_R, btn_U, btn_D};
   assign btn_db = db;

   // Counter runs only while the synchronized level disagrees with the debounced one.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               db[i]  <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      prio_dir = 2'b11;
      if (db[3])      prio_dir = 2'b00;
      else if (db[2]) prio_dir = 2'b01;
      else if (db[1]) prio_dir = 2'b10;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         move_valid <= 1'b0;
         move_dir   <= 2'b00;
         move_count <= 16'h0000;
      end else begin
         case (state)
            StIdle: begin
               if (|db) begin
                  move_valid <= 1'b1;
                  move_dir   <= prio_dir;
                  state      <= StReq;
               end
            end
            StReq: begin
               if (move_ready) begin
                  move_valid <= 1'b0;
                  move_count <= move_count + 16'd1;
                  state      <= StWaitRel;
               end
            end
            StWaitRel: begin
               if (db == 4'b0000) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/move_input_ctrl.md
Name: move_input_ctrl

Overview:
- Upstream stage of the board logic; converts four raw push-buttons into single, debounced, one-per-press move requests.
- Synchronizes and debounces each button, then resolves simultaneous presses by fixed priority.
- Issues a valid/ready request carrying a 2-bit direction code.
- Blocks further requests until every button has been released, so a held button can never produce repeated moves.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (5 ms at 100 MHz); legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each debounce counter; derived, never overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- btn_L  input  1  raw left button, asynchronous, active-high
- btn_R  input  1  raw right button, asynchronous, active-high
- btn_U  input  1  raw up button, asynchronous, active-high
- btn_D  input  1  raw down button, asynchronous, active-high
- move_valid  output  1  move request pending
- move_dir  output  2  direction code: 00=L, 01=R, 10=U, 11=D; held stable while move_valid=1
- move_ready  input  1  board accepts the request this cycle
- move_count  output  16  number of accepted moves; wraps 0xFFFF->0x0000
- btn_db  output  4  debounced levels {L,R,U,D}, bit 3 = L

Behaviour:
- Reset (rst=1 at a clk edge) sets all of the following to 0:
  - synchronizer flops, debounced levels, debounce counters;
  - move_valid, move_dir, move_count, btn_db.
- Reset also forces state to IDLE and overrides every other event in that cycle.
- Synchronizer: two flops per button; raw input reaches the debouncer 2 edges later.
- Debounce, per button:
  - If the synchronized value equals the debounced value, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced value takes the synchronized value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_db.
- FSM states: IDLE, REQ, WAIT_REL.
  - IDLE: if any btn_db bit is 1, latch move_dir by priority L>R>U>D, set move_valid=1, go to REQ. Otherwise stay.
  - REQ: move_valid=1 and move_dir frozen, even if the button is released or another is pressed.
    - On move_ready=1: move_valid=0 from the next cycle, move_count+1, go to WAIT_REL.
  - WAIT_REL: stay until btn_db==4'b0000, then go to IDLE. No request is issued in this state.
- Latency:
  - A raw press held stable from before edge k makes btn_db rise at edge k+2+DEBOUNCE_CYCLES.
  - move_valid rises at edge k+3+DEBOUNCE_CYCLES.
  - Acceptance takes effect at the edge where move_valid=1 and move_ready=1.
- move_ready while move_valid=0 is ignored and does not change move_count.
- move_ready held high permanently: each request lasts exactly one cycle.
- A button still held through reset is treated as a new press: it re-debounces, and one request follows.
- Reset in REQ drops the pending request; move_count returns to 0.
- Simultaneous presses produce exactly one request. The lower-priority button produces nothing until all buttons are released and pressed again.
- Counter wrap: accepting a move at move_count=0xFFFF yields 0x0000, with no flag.

Test Plan (DEBOUNCE_CYCLES=4, move_ready tied 1 unless stated):
- Reset then btn_R=1 held → btn_db=4'b0100 after 6 edges; move_valid=1 for exactly 1 cycle at edge 7 with move_dir=01; move_count=1; no further request while btn_R stays high.
- btn_U pulses high for 3 cycles, then low → btn_db stays 0, move_valid never asserts, move_count unchanged.
- btn_D and btn_L rise in the same cycle → one request with move_dir=00. Release both, press btn_D alone → second request with move_dir=11, move_count=2.
- move_ready=0, press btn_L, release it after move_valid rises, hold move_ready=0 for 10 cycles, then pulse move_ready=1 → move_valid stays 1 with move_dir=00 for all 10 cycles, drops the cycle after acceptance, move_count increments by exactly 1.
- Assert rst while in REQ (move_ready=0) with btn_R still held → move_valid=0 and move_count=0 after the reset edge; one new request with move_dir=01 is issued 7 edges after rst drops.
- Preload via 65535 accepted presses (or a force) to move_count=0xFFFF, accept one more move → move_count=0x0000.
